// File: rtl/vx_mem_load_seq_if.sv
// Handshake bundle between the load sequencer, its cacheline source and the memory loader.
// The master modport is the sequencer's view; slave is the environment's view.
interface vx_mem_load_seq_if #(
    parameter int LINE_W = 512
);
    logic              src_valid;
    logic              src_ready;
    logic [LINE_W-1:0] src_line;
    logic              load_valid;
    logic              load_ready;
    logic [LINE_W-1:0] load_line;
    logic              load_type;

    modport master (
        input  src_valid, src_line, load_ready,
        output src_ready, load_valid, load_line, load_type
    );

    modport slave (
        output src_valid, src_line, load_ready,
        input  src_ready, load_valid, load_line, load_type
    );
endinterface

// File: rtl/vx_mem_load_seq.sv
// Sequences instruction then data cachelines from a source into the memory loader,
// holding the GPU core in reset until every line has been delivered.
module vx_mem_load_seq #(
    parameter int LINE_W  = 512,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_W-1:0]      inst_lines,
    input  logic [CNT_W-1:0]      data_lines,
    vx_mem_load_seq_if.master     bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  core_reset,
    output logic [CNT_W:0]        loaded
);
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INST = 3'd1,
        ST_DATA = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    state_t              state_r, state_nx;
    logic [CNT_W:0]      inst_r, data_r, total_r, fetched_r, loaded_r;
    logic [STALL_W-1:0]  stall_r;
    logic                buf_full_r, buf_type_r;
    logic [LINE_W-1:0]   buf_line_r;
    logic                busy_r, done_r, error_r, core_reset_r;

    logic                active_s, start_acc_s, src_ready_s, fetch_s, deliver_s, timeout_s;
    logic [CNT_W:0]      inst_ext_s, data_ext_s, loaded_inc_s;
    logic [STALL_W-1:0]  stall_inc_s;

    assign inst_ext_s   = {1'b0, inst_lines};
    assign data_ext_s   = {1'b0, data_lines};
    assign loaded_inc_s = loaded_r + (CNT_W+1)'(1);
    assign stall_inc_s  = stall_r + STALL_W'(1);

    assign active_s    = (state_r == ST_INST) || (state_r == ST_DATA);
    // The buffer can refill in the same cycle it drains, giving one line per cycle.
    assign src_ready_s = active_s && (fetched_r < total_r) && (!buf_full_r || bus.load_ready);
    assign fetch_s     = bus.src_valid && src_ready_s;
    assign deliver_s   = buf_full_r && bus.load_ready;
    assign timeout_s   = active_s && !deliver_s && (stall_inc_s == STALL_W'(TIMEOUT));

    assign bus.src_ready  = src_ready_s;
    assign bus.load_valid = buf_full_r;
    assign bus.load_line  = buf_line_r;
    assign bus.load_type  = buf_type_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign error          = error_r;
    assign core_reset     = core_reset_r;
    assign loaded         = loaded_r;

    // Next-state decode; start is only honoured when no sequence is in flight.
    always_comb begin
        state_nx    = state_r;
        start_acc_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    start_acc_s = 1'b1;
                    if (inst_lines != '0) begin
                        state_nx = ST_INST;
                    end else if (data_lines != '0) begin
                        state_nx = ST_DATA;
                    end else begin
                        state_nx = ST_DONE;
                    end
                end else begin
                    state_nx = state_r;
                end
            end
            ST_INST: begin
                if (timeout_s) begin
                    state_nx = ST_ERR;
                end else if (deliver_s && (loaded_inc_s == inst_r)) begin
                    state_nx = (data_r != '0) ? ST_DATA : ST_DONE;
                end else begin
                    state_nx = ST_INST;
                end
            end
            ST_DATA: begin
                if (timeout_s) begin
                    state_nx = ST_ERR;
                end else if (deliver_s && (loaded_inc_s == total_r)) begin
                    state_nx = ST_DONE;
                end else begin
                    state_nx = ST_DATA;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State register and status flags, decoded from the next state so they are registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            core_reset_r <= 1'b1;
        end else begin
            state_r      <= state_nx;
            busy_r       <= (state_nx == ST_INST) || (state_nx == ST_DATA);
            done_r       <= (state_nx == ST_DONE);
            error_r      <= (state_nx == ST_ERR);
            core_reset_r <= (state_nx != ST_DONE);
        end
    end

    // Counters and the one-entry output buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_r     <= '0;
            data_r     <= '0;
            total_r    <= '0;
            fetched_r  <= '0;
            loaded_r   <= '0;
            stall_r    <= '0;
            buf_full_r <= 1'b0;
            buf_type_r <= 1'b0;
            buf_line_r <= '0;
        end else if (start_acc_s) begin
            inst_r     <= inst_ext_s;
            data_r     <= data_ext_s;
            total_r    <= inst_ext_s + data_ext_s;
            fetched_r  <= '0;
            loaded_r   <= '0;
            stall_r    <= '0;
            buf_full_r <= 1'b0;
        end else if (timeout_s) begin
            stall_r    <= stall_inc_s;
            buf_full_r <= 1'b0;
        end else begin
            if (active_s) begin
                stall_r <= deliver_s ? '0 : stall_inc_s;
            end
            if (fetch_s) begin
                buf_line_r <= bus.src_line;
                buf_type_r <= (fetched_r >= inst_r);
                buf_full_r <= 1'b1;
                fetched_r  <= fetched_r + (CNT_W+1)'(1);
            end else if (deliver_s) begin
                buf_full_r <= 1'b0;
            end
            if (deliver_s) begin
                loaded_r <= loaded_inc_s;
            end
        end
    end
endmodule

// File: tb/tb_vx_mem_load_seq.sv
// Scoreboard bench for vx_mem_load_seq: expected lines queued at start, popped on delivery.
module tb_vx_mem_load_seq;
    localparam int LW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] inst_lines = '0;
    logic [CW-1:0] data_lines = '0;
    logic          busy, done, error, core_reset;
    logic [CW:0]   loaded;

    vx_mem_load_seq_if #(.LINE_W(LW)) bus ();

    vx_mem_load_seq #(.LINE_W(LW), .CNT_W(CW), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .inst_lines(inst_lines), .data_lines(data_lines),
        .bus(bus),
        .busy(busy), .done(done), .error(error), .core_reset(core_reset),
        .loaded(loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    logic [LW-1:0] src_q[$];
    logic [LW-1:0] exp_line_q[$];
    logic          exp_type_q[$];
    int src_idx = 0;
    int n_deliv = 0;
    int cyc = 0;
    int first_deliv = 0;
    int last_deliv = 0;
    bit src_on = 1'b0;
    bit ld_rdy = 1'b0;
    bit saw_src_rdy = 1'b0;
    bit saw_lv = 1'b0;
    logic [LW-1:0] held;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, score the handshakes that the next posedge will commit.
    task automatic cycle();
        @(negedge clk);
        bus.load_ready = ld_rdy;
        if (src_on && (src_idx < src_q.size())) begin
            bus.src_valid = 1'b1;
            bus.src_line  = src_q[src_idx];
        end else begin
            bus.src_valid = 1'b0;
            bus.src_line  = '0;
        end
        #1;
        if (bus.src_ready)  saw_src_rdy = 1'b1;
        if (bus.load_valid) saw_lv = 1'b1;
        if (bus.load_valid && bus.load_ready) begin
            if (exp_line_q.size() == 0) begin
                check("extra_delivery", 64'(exp_line_q.size()), 64'd1);
            end else begin
                check("load_line", 64'(bus.load_line), 64'(exp_line_q.pop_front()));
                check("load_type", 64'(bus.load_type), 64'(exp_type_q.pop_front()));
            end
            n_deliv++;
            if (n_deliv == 1) first_deliv = cyc;
            last_deliv = cyc;
        end
        if (bus.src_valid && bus.src_ready) src_idx++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_seq(input int ni, input int nd, input logic [LW-1:0] base);
        src_q.delete();
        exp_line_q.delete();
        exp_type_q.delete();
        src_idx = 0;
        n_deliv = 0;
        saw_src_rdy = 1'b0;
        saw_lv = 1'b0;
        for (int i = 0; i < ni + nd; i++) begin
            src_q.push_back(base + LW'(i));
            exp_line_q.push_back(base + LW'(i));
            exp_type_q.push_back(i >= ni);
        end
        inst_lines = CW'(ni);
        data_lines = CW'(nd);
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic run_done(input int budget);
        int k = 0;
        while (!(done || error) && (k < budget)) begin
            cycle();
            k++;
        end
        check("bound_done", 64'(done), 64'd1);
    endtask

    initial begin
        bus.src_valid  = 1'b0;
        bus.src_line   = '0;
        bus.load_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_src_ready",  64'(bus.src_ready), 64'd0);
        check("rst_load_valid", 64'(bus.load_valid), 64'd0);
        check("rst_load_line",  64'(bus.load_line), 64'd0);
        check("rst_load_type",  64'(bus.load_type), 64'd0);
        check("rst_busy",       64'(busy), 64'd0);
        check("rst_done",       64'(done), 64'd0);
        check("rst_error",      64'(error), 64'd0);
        check("rst_core_reset", 64'(core_reset), 64'd1);
        check("rst_loaded",     64'(loaded), 64'd0);
        reset = 1'b1;
        cycle();
        cycle();
        check("idle_busy", 64'(busy), 64'd0);

        // Full-rate sequence, 3 inst + 2 data.
        src_on = 1'b1;
        ld_rdy = 1'b1;
        start_seq(3, 2, 32'h1000_0000);
        check("t030_busy", 64'(busy), 64'd1);
        run_done(30);
        check("t030_deliv",      64'(n_deliv), 64'd5);
        check("t030_back2back",  64'(last_deliv - first_deliv), 64'd4);
        check("t030_core_reset", 64'(core_reset), 64'd0);
        check("t030_loaded",     64'(loaded), 64'd5);
        check("t030_q_empty",    64'(exp_line_q.size()), 64'd0);

        // Empty sequence goes straight to DONE.
        start_seq(0, 0, 32'h2000_0000);
        check("t031_done",       64'(done), 64'd1);
        check("t031_core_reset", 64'(core_reset), 64'd0);
        cycle();
        cycle();
        check("t031_no_src_rdy", 64'(saw_src_rdy), 64'd0);
        check("t031_no_lv",      64'(saw_lv), 64'd0);
        check("t031_loaded",     64'(loaded), 64'd0);

        // Back-pressure on the first line.
        ld_rdy = 1'b0;
        start_seq(2, 1, 32'h3000_0000);
        check("t031_core_reset_rises", 64'(core_reset), 64'd1);
        for (int k = 0; (k < 5) && !bus.load_valid; k++) cycle();
        check("t032_valid", 64'(bus.load_valid), 64'd1);
        held = bus.load_line;
        check("t032_first", 64'(held), 64'h3000_0000);
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("t032_stable",   64'(bus.load_line), 64'(held));
            check("t032_no_fetch", 64'(bus.src_ready), 64'd0);
        end
        ld_rdy = 1'b1;
        bus.load_ready = 1'b1;
        #1;
        check("t032_rdy_hi", 64'(bus.src_ready), 64'd1);
        run_done(20);
        check("t032_loaded", 64'(loaded), 64'd3);
        check("t032_q_empty", 64'(exp_line_q.size()), 64'd0);

        // Source never responds: timeout after 8 stalled cycles.
        src_on = 1'b0;
        start_seq(2, 2, 32'h4000_0000);
        begin
            int k = 0;
            while (!error && (k < 20)) begin
                cycle();
                k++;
            end
            check("t033_cycles", 64'(k), 64'd8);
        end
        check("t033_error",      64'(error), 64'd1);
        check("t033_busy",       64'(busy), 64'd0);
        check("t033_core_reset", 64'(core_reset), 64'd1);
        check("t033_lv",         64'(bus.load_valid), 64'd0);
        src_on = 1'b1;
        start_seq(1, 1, 32'h5000_0000);
        check("t033_err_clr", 64'(error), 64'd0);
        run_done(20);
        check("t033_loaded", 64'(loaded), 64'd2);

        // Reset in the middle of a 4-line sequence.
        start_seq(2, 2, 32'h6000_0000);
        for (int k = 0; (k < 20) && (n_deliv < 2); k++) cycle();
        check("t034_pre_loaded", 64'(loaded), 64'd2);
        reset = 1'b0;
        #1;
        check("t034_busy",   64'(busy), 64'd0);
        check("t034_loaded", 64'(loaded), 64'd0);
        check("t034_lv",     64'(bus.load_valid), 64'd0);
        check("t034_srdy",   64'(bus.src_ready), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        cycle();
        cycle();
        check("t034_idle", 64'(busy | done | error), 64'd0);
        start_seq(3, 1, 32'h7000_0000);
        run_done(20);
        check("t034_deliv",  64'(n_deliv), 64'd4);
        check("t034_loaded", 64'(loaded), 64'd4);

        // Start while busy is ignored.
        start_seq(3, 1, 32'h8000_0000);
        cycle();
        inst_lines = 8'd7;
        data_lines = 8'd7;
        start = 1'b1;
        cycle();
        start = 1'b0;
        run_done(30);
        check("t035_deliv",   64'(n_deliv), 64'd4);
        check("t035_loaded",  64'(loaded), 64'd4);
        check("t035_q_empty", 64'(exp_line_q.size()), 64'd0);
        cycle();
        check("t035_stays_done", 64'(done), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule
